layer_rd_ctl: RTL and testbench
===============================

Name: layer_rd_ctl

Overview:
Read-side counterpart of the cube's SPI-to-RAM write path. After a complete frame has been written into the eight layer RAMs, it scans LED index 0..63. For each index it fetches the remap address from byte 3, then fetches the 24-bit colour word at the remapped address from all eight layers in parallel. It then serialises the eight colour words MSB-first, one bit per channel per handshake, to the 8-channel NeoPixel waveform generator. Sits between the layer RAM read ports and the waveform generator.

Parameters:
LED_NUM, 64, LEDs per layer chain; index/address width is clog2(LED_NUM) = 6.
RST_CYCLES, 16'd4000, clk_in cycles of idle (reset code) after the last bit of a frame.

Ports:
clk_in  input  1  clock
rst_n_in  input  1  async active-low reset
frame_rdy_in  input  1  one-cycle pulse: frame fully written, start readout
rd_en_out  output  1  RAM read strobe, shared by all 8 layer RAMs
rd_addr_out  output  6  RAM read address, shared
rd_data_in  input  8x32  per-layer RAM read data {remap[7:0], c2, c1, c0}, valid 1 cycle after rd_en_out
bit_vld_out  output  1  bit slice valid
bit_data_out  output  8  bit slice, bit n = current bit for layer n
bit_rdy_in  input  1  waveform generator accepts slice when bit_vld_out & bit_rdy_in
busy_out  output  1  readout in progress (any state except IDLE)
frame_done_out  output  1  one-cycle pulse when reset-code period ends

Behaviour:
- Reset (rst_n_in = 0, asynchronous, active-low; clock clk_in): state IDLE. All outputs 0. Index, bit counter, shift registers and pending flag cleared. Reset mid-frame aborts immediately with no partial-pixel completion.
- IDLE: on frame_rdy_in -> RD_ADDR; index <= 0.
- RD_ADDR: rd_en_out = 1, rd_addr_out = index; -> WAIT_ADDR.
- WAIT_ADDR: latch remap <= rd_data_in[0][29:24] (layer 0 byte 3; the remap table is identical across layers); -> RD_DATA.
- RD_DATA: rd_en_out = 1, rd_addr_out = remap; -> WAIT_DATA.
- WAIT_DATA: for each layer n, shreg[n] <= rd_data_in[n][23:0]; bit_cnt <= 23; -> SHIFT.
- SHIFT: bit_vld_out = 1; bit_data_out[n] = shreg[n][23]. On bit_rdy_in:
  - shift all shreg left by 1; bit_cnt -= 1.
  - If bit_cnt was 0 and index == LED_NUM-1 -> LATCH with counter = RST_CYCLES-1.
  - If bit_cnt was 0 otherwise -> RD_ADDR with index += 1.
  - bit_vld_out holds and bit_data_out is stable while bit_rdy_in = 0.
- Byte order on the wire: byte 2 first, then byte 1, then byte 0, each MSB-first, matching write order.
- Per-pixel overhead: 4 non-handshake cycles between the last bit of one pixel and the first bit of the next. Latency from frame_rdy_in to first bit_vld_out = 5 cycles.
- LATCH: bit_vld_out = 0; counter decrements each cycle. At 0: frame_done_out pulses for 1 cycle; -> RD_ADDR (index 0) if pending, else IDLE; pending cleared.
- frame_rdy_in while busy: set pending. Multiple pulses collapse into one. A frame is never restarted mid-scan.
- frame_rdy_in coincident with frame_done_out: treated as pending, so the next scan starts immediately.
- Remap values >= LED_NUM: upper bits ignored (6-bit truncation).
- rd_en_out is asserted only in RD_ADDR/RD_DATA. rd_addr_out is 0 when rd_en_out = 0.

Decomposition:
- Package cube_pkg holds:
  - state enum rd_state_t {IDLE, RD_ADDR, WAIT_ADDR, RD_DATA, WAIT_DATA, SHIFT, LATCH};
  - LED_NUM, ADDR_W, COLOR_W = 24;
  - the command constants shared with the write path (8'h2a/2b/2c).
- One sub-module, pixel_shreg: 8-lane 24-bit parallel-load shift register with load/shift enables. The FSM, counters and pending logic stay in layer_rd_ctl.

Test Plan:
- Layer n RAM word at addr k = {k, 8'h10+n, 8'h20+n, 8'h30+n}, identity remap, bit_rdy_in tied 1, frame_rdy_in pulse -> first 8 slices reflect 8'h10+n MSB-first per lane; 64×24 = 1536 slices total; frame_done_out pulses exactly RST_CYCLES cycles after the last slice.
- Reverse remap (byte 3 at index i = 63-i) -> the first pixel shifted out uses colours from addr 63 and the last from addr 0; rd_addr_out sequence begins 0, 63, 1, 62.
- bit_rdy_in random 30% duty -> bit_data_out stable while stalled; no slice lost or duplicated; per-lane serial stream matches the reference model.
- Two frame_rdy_in pulses during SHIFT of pixel 10 -> exactly one extra frame follows immediately after frame_done_out, then IDLE.
- Assert rst_n_in during pixel 30 SHIFT -> all outputs 0 asynchronously; a new frame_rdy_in restarts at index 0.
- frame_rdy_in on the same cycle as frame_done_out -> next RD_ADDR on the following cycle with index 0.

Source files
------------

// File: rtl/cube_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cube_pkg                                                                   |
// | Shared types and constants for the LED cube layer RAM read/write paths.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cube_pkg;

  localparam int LED_NUM   = 64;
  localparam int ADDR_W    = $clog2(LED_NUM);
  localparam int COLOR_W   = 24;
  localparam int LAYER_NUM = 8;
  localparam int WORD_W    = 32;

  // SPI command bytes understood by the write path
  localparam logic [7:0] CMD_FRAME_START = 8'h2a;
  localparam logic [7:0] CMD_LAYER_DATA  = 8'h2b;
  localparam logic [7:0] CMD_FRAME_END   = 8'h2c;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ADDR   = 3'd1,
    WAIT_ADDR = 3'd2,
    RD_DATA   = 3'd3,
    WAIT_DATA = 3'd4,
    SHIFT     = 3'd5,
    LATCH     = 3'd6
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_shreg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_shreg                                                                |
// | Per-layer parallel-load colour shift registers, MSB shifted out first.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pixel_shreg
  import cube_pkg::*;
#(
  parameter int LANES = LAYER_NUM,
  parameter int WIDTH = COLOR_W
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         load_in,
  input  logic                         shift_in,
  input  logic [LANES-1:0][WIDTH-1:0]  data_in,
  output logic [LANES-1:0]             msb_out
);

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [WIDTH-1:0] r_sh;

    // load wins over shift so a new pixel never inherits a stale bit
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        r_sh <= '0;
      end else if (load_in) begin
        r_sh <= data_in[n];
      end else if (shift_in) begin
        r_sh <= {r_sh[WIDTH-2:0], 1'b0};
      end
    end

    assign msb_out[n] = r_sh[WIDTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/layer_rd_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | layer_rd_ctl                                                               |
// | Scans the eight layer RAMs through the remap table and serialises colour   |
// | words as 8-lane bit slices to the NeoPixel waveform generator.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module layer_rd_ctl #(
  parameter int          LED_NUM    = 64,
  parameter logic [15:0] RST_CYCLES = 16'd4000
) (
  input  logic                                                      clk_in,
  input  logic                                                      rst_n_in,
  input  logic                                                      frame_rdy_in,
  output logic                                                      rd_en_out,
  output logic [$clog2(LED_NUM)-1:0]                                rd_addr_out,
  input  logic [cube_pkg::LAYER_NUM-1:0][cube_pkg::WORD_W-1:0]      rd_data_in,
  output logic                                                      bit_vld_out,
  output logic [cube_pkg::LAYER_NUM-1:0]                            bit_data_out,
  input  logic                                                      bit_rdy_in,
  output logic                                                      busy_out,
  output logic                                                      frame_done_out
);

  import cube_pkg::*;

  localparam int                c_addr_w   = $clog2(LED_NUM);
  localparam int                c_bit_w    = $clog2(COLOR_W);
  localparam logic [c_addr_w-1:0] c_last_idx = c_addr_w'(LED_NUM - 1);

  rd_state_t                                r_state;
  rd_state_t                                w_state_nxt;
  logic [c_addr_w-1:0]                      r_index;
  logic [c_addr_w-1:0]                      r_remap;
  logic [c_bit_w-1:0]                       r_bit_cnt;
  logic [15:0]                              r_rst_cnt;
  logic                                     r_pending;
  logic                                     w_load;
  logic                                     w_shift;
  logic [LAYER_NUM-1:0]                     w_msb;
  logic [LAYER_NUM-1:0][COLOR_W-1:0]        w_colors;
  logic                                     w_unused;

  // only the colour bytes and the layer-0 remap byte are consumed
  assign w_unused = ^rd_data_in;

  always_comb begin
    for (int n = 0; n < LAYER_NUM; n++) begin
      w_colors[n] = rd_data_in[n][COLOR_W-1:0];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    rd_en_out      = 1'b0;
    rd_addr_out    = '0;
    bit_vld_out    = 1'b0;
    frame_done_out = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_rdy_in) begin
          w_state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        rd_en_out   = 1'b1;
        rd_addr_out = r_index;
        w_state_nxt = WAIT_ADDR;
      end
      WAIT_ADDR: begin
        w_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rd_en_out   = 1'b1;
        rd_addr_out = r_remap;
        w_state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        w_load      = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        bit_vld_out = 1'b1;
        if (bit_rdy_in) begin
          w_shift = 1'b1;
          if (r_bit_cnt == '0) begin
            w_state_nxt = (r_index == c_last_idx) ? LATCH : RD_ADDR;
          end
        end
      end
      LATCH: begin
        if (r_rst_cnt == '0) begin
          frame_done_out = 1'b1;
          // a request landing on the done cycle starts the next scan directly
          w_state_nxt    = (r_pending || frame_rdy_in) ? RD_ADDR : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_index   <= '0;
      r_remap   <= '0;
      r_bit_cnt <= '0;
      r_rst_cnt <= '0;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_index <= '0;
        end
        WAIT_ADDR: begin
          r_remap <= rd_data_in[0][COLOR_W +: c_addr_w];
        end
        WAIT_DATA: begin
          r_bit_cnt <= c_bit_w'(COLOR_W - 1);
        end
        SHIFT: begin
          if (bit_rdy_in) begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
            if (r_bit_cnt == '0) begin
              if (r_index == c_last_idx) begin
                r_rst_cnt <= RST_CYCLES - 16'd1;
              end else begin
                r_index <= r_index + 1'b1;
              end
            end
          end
        end
        LATCH: begin
          if (r_rst_cnt != '0) begin
            r_rst_cnt <= r_rst_cnt - 16'd1;
          end else begin
            r_index <= '0;
          end
        end
        default: begin
        end
      endcase

      if (frame_done_out) begin
        r_pending <= 1'b0;
      end else if (frame_rdy_in && (r_state != IDLE)) begin
        r_pending <= 1'b1;
      end
    end
  end

  pixel_shreg #(
    .LANES (LAYER_NUM),
    .WIDTH (COLOR_W)
  ) u_shreg (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .load_in  (w_load),
    .shift_in (w_shift),
    .data_in  (w_colors),
    .msb_out  (w_msb)
  );

  assign bit_data_out = (r_state == SHIFT) ? w_msb : '0;
  assign busy_out     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_layer_rd_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_layer_rd_ctl                                                            |
// | Randomised bench for layer_rd_ctl against a frame-level reference model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_layer_rd_ctl;

  localparam int LEDS   = 64;
  localparam int LAYERS = 8;
  localparam int RSTC   = 4000;
  localparam int SLICES = LEDS * 24;

  logic                    clk_in       = 1'b0;
  logic                    rst_n_in     = 1'b0;
  logic                    frame_rdy_in = 1'b0;
  logic                    bit_rdy_in   = 1'b0;
  logic [LAYERS-1:0][31:0] rd_data_in;
  logic                    rd_en_out;
  logic [5:0]              rd_addr_out;
  logic                    bit_vld_out;
  logic [LAYERS-1:0]       bit_data_out;
  logic                    busy_out;
  logic                    frame_done_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  layer_rd_ctl #(
    .LED_NUM    (LEDS),
    .RST_CYCLES (16'(RSTC))
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .frame_rdy_in   (frame_rdy_in),
    .rd_en_out      (rd_en_out),
    .rd_addr_out    (rd_addr_out),
    .rd_data_in     (rd_data_in),
    .bit_vld_out    (bit_vld_out),
    .bit_data_out   (bit_data_out),
    .bit_rdy_in     (bit_rdy_in),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out)
  );

  // layer RAMs: registered read, data one cycle after the strobe
  logic [31:0] mem [LAYERS][LEDS];
  always @(posedge clk_in) begin
    if (rd_en_out) begin
      for (int n = 0; n < LAYERS; n++) rd_data_in[n] <= mem[n][rd_addr_out];
    end
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int rdy_mode = 0;
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      bit_rdy_in = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end
  end

  // observation queues
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         done_cyc[$];
  logic [5:0] addr_q[$];
  int         stall_err, stall_cnt, first_vld_cyc, rdy_cyc;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (prev_hold) begin
        stall_cnt++;
        if (!bit_vld_out || bit_data_out !== prev_data) stall_err++;
      end
      prev_hold = bit_vld_out && !bit_rdy_in;
      prev_data = bit_data_out;
      if (bit_vld_out && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bit_vld_out && bit_rdy_in) begin
        got_q.push_back(bit_data_out);
        got_cyc.push_back(cyc);
      end
      if (frame_done_out) done_cyc.push_back(cyc);
      if (rd_en_out) addr_q.push_back(rd_addr_out);
      if (frame_rdy_in && rdy_cyc < 0) rdy_cyc = cyc;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    done_cyc.delete();
    addr_q.delete();
    stall_err     = 0;
    stall_cnt     = 0;
    first_vld_cyc = -1;
    rdy_cyc       = -1;
  endtask

  // reference model: walk LED indices, look up remap, emit colour bits MSB-first
  logic [7:0] exp_q[$];
  int         exp_addr[$];

  task automatic build_model(input int frames);
    exp_q.delete();
    exp_addr.delete();
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < LEDS; i++) begin
        int a;
        a = int'(mem[0][i] >> 24) % LEDS;
        exp_addr.push_back(i);
        exp_addr.push_back(a);
        for (int b = 23; b >= 0; b--) begin
          logic [7:0] s;
          for (int n = 0; n < LAYERS; n++) s[n] = mem[n][a][b];
          exp_q.push_back(s);
        end
      end
    end
  endtask

  function automatic int slice_diff();
    int lim;
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return lim;
    return -1;
  endfunction

  function automatic int addr_diff();
    int lim;
    lim = (addr_q.size() < exp_addr.size()) ? addr_q.size() : exp_addr.size();
    for (int i = 0; i < lim; i++) if (int'(addr_q[i]) != exp_addr[i]) return i;
    if (addr_q.size() != exp_addr.size()) return lim;
    return -1;
  endfunction

  // mode 0: identity pattern; 1: random colours, reverse remap with junk upper bits; 2: all random
  task automatic fill_mem(input int mode);
    for (int k = 0; k < LEDS; k++) begin
      logic [7:0] r;
      r = (mode == 0) ? 8'(k) :
          (mode == 1) ? {2'($urandom_range(0, 3)), 6'(63 - k)} : 8'($urandom);
      for (int n = 0; n < LAYERS; n++) begin
        if (mode == 0) mem[n][k] = {r, 8'h10 + 8'(n), 8'h20 + 8'(n), 8'h30 + 8'(n)};
        else           mem[n][k] = {r, 24'($urandom)};
      end
    end
    // layers beyond 0 carry a different byte 3 to prove only layer 0 is used
    if (mode == 2) for (int k = 0; k < LEDS; k++) mem[5][k][31:24] = 8'($urandom);
  endtask

  task automatic pulse_rdy();
    @(posedge clk_in);
    #1;
    frame_rdy_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_rdy_in = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (done_cyc.size() < n && k < budget) begin
      @(posedge clk_in);
      k++;
    end
    ok = (done_cyc.size() >= n);
  endtask

  task automatic test_reset();
    logic [18:0] outs;
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy_out); end
    n_cmp++; if (bit_vld_out !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b exp 0", bit_vld_out); end
    n_cmp++; if (rd_en_out !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got %b exp 0", rd_en_out); end
    outs = {rd_addr_out, bit_data_out, frame_done_out, busy_out, bit_vld_out, rd_en_out, 1'b0};
    n_cmp++; if (outs !== 19'd0) begin n_bad++; $display("FAIL reset_outputs got %h exp 0", outs); end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);
  endtask

  task automatic test_identity_frame();
    bit ok;
    int d;
    fill_mem(0);
    build_model(1);
    rdy_mode = 0;
    clear_mon();
    pulse_rdy();
    wait_dones(1, 8000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL id_done_timeout got %0d dones exp 1", done_cyc.size()); end
    n_cmp++; if (first_vld_cyc - rdy_cyc !== 5) begin n_bad++; $display("FAIL id_latency got %0d exp 5", first_vld_cyc - rdy_cyc); end
    n_cmp++; if (got_q.size() !== SLICES) begin n_bad++; $display("FAIL id_slice_count got %0d exp %0d", got_q.size(), SLICES); end
    for (int b = 0; b < 8; b++) begin
      logic [7:0] e, bv;
      for (int n = 0; n < LAYERS; n++) begin
        bv   = 8'h10 + 8'(n);
        e[n] = bv[7-b];
      end
      n_cmp++;
      if (got_q.size() <= b || got_q[b] !== e) begin
        n_bad++;
        $display("FAIL id_first_byte slice %0d got %h exp %h", b, (got_q.size() > b) ? got_q[b] : 8'hxx, e);
      end
    end
    d = slice_diff();
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL id_stream first diff at %0d got_n %0d exp_n %0d", d, got_q.size(), exp_q.size()); end
    if (got_cyc.size() > 24) begin
      n_cmp++; if (got_cyc[24] - got_cyc[23] !== 5) begin n_bad++; $display("FAIL id_pixel_gap got %0d exp 5", got_cyc[24] - got_cyc[23]); end
    end
    if (ok && got_cyc.size() > 0) begin
      n_cmp++;
      if (done_cyc[0] - got_cyc[got_cyc.size()-1] !== RSTC) begin
        n_bad++;
        $display("FAIL id_latch_len got %0d exp %0d", done_cyc[0] - got_cyc[got_cyc.size()-1], RSTC);
      end
    end
    repeat (10) @(posedge clk_in);
    #1;
    n_cmp++; if (busy_out !== 1'b0 || done_cyc.size() !== 1) begin n_bad++; $display("FAIL id_idle got busy %b dones %0d exp 0/1", busy_out, done_cyc.size()); end
  endtask

  task automatic test_reverse_remap();
    bit ok;
    int d;
    logic [23:0] a4;
    fill_mem(1);
    build_model(1);
    rdy_mode = 0;
    clear_mon();
    pulse_rdy();
    wait_dones(1, 8000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rev_done_timeout got %0d dones exp 1", done_cyc.size()); end
    a4 = (addr_q.size() >= 4) ? {addr_q[0], addr_q[1], addr_q[2], addr_q[3]} : 24'hxxxxxx;
    n_cmp++; if (a4 !== {6'd0, 6'd63, 6'd1, 6'd62}) begin n_bad++; $display("FAIL rev_addr_head got %h exp %h", a4, {6'd0, 6'd63, 6'd1, 6'd62}); end
    d = addr_diff();
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL rev_addr_seq first diff at %0d got_n %0d", d, addr_q.size()); end
    d = slice_diff();
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL rev_stream first diff at %0d got_n %0d exp_n %0d", d, got_q.size(), exp_q.size()); end
    repeat (5) @(posedge clk_in);
  endtask

  task automatic test_random_stall();
    bit ok;
    int d;
    fill_mem(2);
    build_model(1);
    rdy_mode = 1;
    clear_mon();
    pulse_rdy();
    wait_dones(1, 16000, ok);
    rdy_mode = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_done_timeout got %0d dones exp 1", done_cyc.size()); end
    n_cmp++; if (got_q.size() !== SLICES) begin n_bad++; $display("FAIL stall_slice_count got %0d exp %0d", got_q.size(), SLICES); end
    n_cmp++; if (stall_err !== 0 || stall_cnt == 0) begin n_bad++; $display("FAIL stall_hold got %0d unstable of %0d stalls exp 0", stall_err, stall_cnt); end
    d = slice_diff();
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL stall_stream first diff at %0d got_n %0d exp_n %0d", d, got_q.size(), exp_q.size()); end
    repeat (5) @(posedge clk_in);
  endtask

  task automatic test_pending();
    bit ok;
    int d, k;
    fill_mem(2);
    build_model(2);
    rdy_mode = 0;
    clear_mon();
    pulse_rdy();
    k = 0;
    while (got_q.size() < 10 * 24 + 1 && k < 2000) begin @(posedge clk_in); k++; end
    pulse_rdy();
    @(posedge clk_in);
    pulse_rdy();
    wait_dones(2, 14000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pend_done_timeout got %0d dones exp 2", done_cyc.size()); end
    repeat (20) @(posedge clk_in);
    #1;
    n_cmp++; if (busy_out !== 1'b0 || done_cyc.size() !== 2) begin n_bad++; $display("FAIL pend_frames got busy %b dones %0d exp 0/2", busy_out, done_cyc.size()); end
    d = slice_diff();
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL pend_stream first diff at %0d got_n %0d exp_n %0d", d, got_q.size(), exp_q.size()); end
    if (got_cyc.size() > SLICES && done_cyc.size() > 0) begin
      n_cmp++;
      if (got_cyc[SLICES] - done_cyc[0] !== 5) begin
        n_bad++;
        $display("FAIL pend_restart_gap got %0d exp 5", got_cyc[SLICES] - done_cyc[0]);
      end
    end
  endtask

  task automatic test_coincident();
    bit ok;
    int d, k;
    build_model(2);
    rdy_mode = 0;
    clear_mon();
    pulse_rdy();
    k = 0;
    while (k < 8000) begin
      @(posedge clk_in);
      #1;
      k++;
      if (frame_done_out) break;
    end
    n_cmp++; if (frame_done_out !== 1'b1) begin n_bad++; $display("FAIL coin_done_timeout got %b exp 1", frame_done_out); end
    frame_rdy_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_rdy_in = 1'b0;
    n_cmp++;
    if ({rd_en_out, rd_addr_out} !== {1'b1, 6'd0}) begin
      n_bad++;
      $display("FAIL coin_restart got en %b addr %0d exp 1/0", rd_en_out, rd_addr_out);
    end
    wait_dones(2, 8000, ok);
    repeat (20) @(posedge clk_in);
    #1;
    n_cmp++; if (!ok || busy_out !== 1'b0 || done_cyc.size() !== 2) begin n_bad++; $display("FAIL coin_frames got busy %b dones %0d exp 0/2", busy_out, done_cyc.size()); end
    d = slice_diff();
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL coin_stream first diff at %0d got_n %0d exp_n %0d", d, got_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int d, k;
    logic [18:0] outs;
    fill_mem(2);
    rdy_mode = 0;
    clear_mon();
    pulse_rdy();
    k = 0;
    while (got_q.size() < 30 * 24 + 5 && k < 2000) begin @(posedge clk_in); k++; end
    @(negedge clk_in);
    n_cmp++; if (bit_vld_out !== 1'b1) begin n_bad++; $display("FAIL mid_in_shift got %b exp 1", bit_vld_out); end
    #2;
    rst_n_in = 1'b0;
    #1;
    outs = {rd_addr_out, bit_data_out, frame_done_out, busy_out, bit_vld_out, rd_en_out, 1'b0};
    n_cmp++; if (outs !== 19'd0) begin n_bad++; $display("FAIL mid_async_reset got %h exp 0", outs); end
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    build_model(1);
    clear_mon();
    pulse_rdy();
    k = 0;
    while (got_q.size() < 24 && k < 200) begin @(posedge clk_in); k++; end
    n_cmp++; if (addr_q.size() == 0 || addr_q[0] !== 6'd0) begin n_bad++; $display("FAIL mid_restart_index got %0d exp 0", (addr_q.size() > 0) ? addr_q[0] : 6'h3f); end
    n_cmp++; if (first_vld_cyc - rdy_cyc !== 5) begin n_bad++; $display("FAIL mid_restart_latency got %0d exp 5", first_vld_cyc - rdy_cyc); end
    d = -1;
    for (int i = 0; i < 24; i++) begin
      if (d < 0 && (got_q.size() <= i || got_q[i] !== exp_q[i])) d = i;
    end
    n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL mid_restart_pixel0 first diff at %0d got_n %0d", d, got_q.size()); end
    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_identity_frame();
    test_reverse_remap();
    test_random_stall();
    test_pending();
    test_coincident();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
